// File: rtl/multi_lane_tx_striper.sv
// rtl/multi_lane_tx_striper.sv - stripes a byte stream across 1..NUM_LANES lanes with Gen1 scrambling and PAD fill
// Optional SKP ordered-set insertion is enabled by defining MLC_SKP_INSERT_EN.
module multi_lane_tx_striper #(
  parameter int NUM_LANES    = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_LANES-1:0]            lane_enable_i,
  input  logic [DATA_WIDTH-1:0]           data_frame_i,
  input  logic                            data_frame_valid_i,
  input  logic                            data_frame_last_i,
  output logic                            data_frame_ready_o,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_symbol_o,
  output logic [NUM_LANES-1:0]            lane_is_k_o,
  output logic [NUM_LANES-1:0]            lane_symbol_valid_o
);

  localparam int IDXW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNTW = $clog2(NUM_LANES + 1);
  localparam logic [DATA_WIDTH-1:0] PAD_SYM = 8'hF7;

`ifdef MLC_SKP_INSERT_EN
  localparam logic [DATA_WIDTH-1:0] COM_SYM = 8'hBC;
  localparam logic [DATA_WIDTH-1:0] SKP_SYM = 8'h1C;
  typedef enum logic [1:0] {IDLE, FILL, SKP_COM, SKP_OS} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL} state_t;
`endif

  state_t                            state_q, state_d;
  logic [IDXW-1:0]                   idx_q, idx_d;
  logic [CNTW-1:0]                   a_q, a_d, a_eff;
  logic [15:0]                       lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0]             slot_q [NUM_LANES];
  logic [DATA_WIDTH-1:0]             slot_d [NUM_LANES];
  logic [NUM_LANES*DATA_WIDTH-1:0]   sym_q, sym_d;
  logic [NUM_LANES-1:0]              k_q, k_d, vld_q, vld_d;
  logic                              ready_q, ready_d;
  logic [DATA_WIDTH-1:0]             mask;
  logic                              accept, stripe_done;
`ifdef MLC_SKP_INSERT_EN
  logic [15:0]                       cnt_q, cnt_d;
  logic [1:0]                        os_q, os_d;
  state_t                            ret_q, ret_d;
`else
  logic                              unused_skp_interval;
  assign unused_skp_interval = ^SKP_INTERVAL;
`endif

  // Galois x^16+x^5+x^4+x^3+1: feedback from bit 15 into bits 0,3,4,5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = lfsr_step(t);
    lfsr_adv = t;
  endfunction

  function automatic logic [7:0] lfsr_mask(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      lfsr_mask[i] = t[15];
      t = lfsr_step(t);
    end
  endfunction

  function automatic logic [CNTW-1:0] lane_count(input logic [NUM_LANES-1:0] m);
    lane_count = CNTW'(1);
    for (int p = 0; p <= 4; p++) begin
      if ((1 << p) <= NUM_LANES && m == NUM_LANES'((64'd1 << (1 << p)) - 64'd1))
        lane_count = CNTW'(1 << p);
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    lfsr_d      = lfsr_q;
    slot_d      = slot_q;
    sym_d       = '0;
    k_d         = '0;
    vld_d       = '0;
    stripe_done = 1'b0;
`ifdef MLC_SKP_INSERT_EN
    cnt_d       = cnt_q;
    os_d        = os_q;
    ret_d       = ret_q;
`endif
    a_eff  = (state_q == IDLE) ? lane_count(lane_enable_i) : a_q;
    mask   = lfsr_mask(lfsr_q);
    accept = data_frame_valid_i && ready_q;
    if (state_q == IDLE) a_d = a_eff;

    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          slot_d[idx_q] = data_frame_i;
          stripe_done = data_frame_last_i || (CNTW'(idx_q) == a_eff - CNTW'(1));
          if (stripe_done) begin
            // Slots past the completing byte become PAD within this same stripe.
            for (int n = 0; n < NUM_LANES; n++) begin
              if (CNTW'(n) < a_eff) begin
                vld_d[n] = 1'b1;
                if (CNTW'(n) < CNTW'(idx_q)) begin
                  sym_d[n*DATA_WIDTH +: DATA_WIDTH] = slot_q[n] ^ mask;
                end else if (CNTW'(n) == CNTW'(idx_q)) begin
                  sym_d[n*DATA_WIDTH +: DATA_WIDTH] = data_frame_i ^ mask;
                end else begin
                  sym_d[n*DATA_WIDTH +: DATA_WIDTH] = PAD_SYM;
                  k_d[n] = 1'b1;
                end
              end
            end
            lfsr_d  = lfsr_adv(lfsr_q);
            idx_d   = '0;
            state_d = data_frame_last_i ? IDLE : FILL;
`ifdef MLC_SKP_INSERT_EN
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = FILL;
          end
        end
      end
`ifdef MLC_SKP_INSERT_EN
      SKP_COM: begin
        for (int n = 0; n < NUM_LANES; n++) begin
          if (CNTW'(n) < a_q) begin
            sym_d[n*DATA_WIDTH +: DATA_WIDTH] = COM_SYM;
            k_d[n]   = 1'b1;
            vld_d[n] = 1'b1;
          end
        end
        lfsr_d  = 16'hFFFF;
        os_d    = 2'd0;
        state_d = SKP_OS;
      end
      SKP_OS: begin
        for (int n = 0; n < NUM_LANES; n++) begin
          if (CNTW'(n) < a_q) begin
            sym_d[n*DATA_WIDTH +: DATA_WIDTH] = SKP_SYM;
            k_d[n]   = 1'b1;
            vld_d[n] = 1'b1;
          end
        end
        if (os_q == 2'd2) begin
          cnt_d   = '0;
          state_d = ret_q;
        end else begin
          os_d = os_q + 2'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef MLC_SKP_INSERT_EN
    // A due SKP only starts on a stripe boundary; the interrupted state resumes afterwards.
    if ((state_q == IDLE || state_q == FILL) && cnt_d >= 16'(SKP_INTERVAL) && idx_d == '0) begin
      ret_d   = state_d;
      state_d = SKP_COM;
    end
`endif
    ready_d = (state_d == IDLE) || (state_d == FILL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= CNTW'(1);
      lfsr_q  <= 16'hFFFF;
      for (int n = 0; n < NUM_LANES; n++) slot_q[n] <= '0;
      sym_q   <= '0;
      k_q     <= '0;
      vld_q   <= '0;
      ready_q <= 1'b0;
`ifdef MLC_SKP_INSERT_EN
      cnt_q   <= '0;
      os_q    <= '0;
      ret_q   <= IDLE;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      lfsr_q  <= lfsr_d;
      slot_q  <= slot_d;
      sym_q   <= sym_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      ready_q <= ready_d;
`ifdef MLC_SKP_INSERT_EN
      cnt_q   <= cnt_d;
      os_q    <= os_d;
      ret_q   <= ret_d;
`endif
    end
  end

  assign data_frame_ready_o  = ready_q;
  assign lane_symbol_o       = sym_q;
  assign lane_is_k_o         = k_q;
  assign lane_symbol_valid_o = vld_q;

endmodule

// File: tb/tb_multi_lane_tx_striper.sv
// tb/tb_multi_lane_tx_striper.sv - directed self-checking bench for multi_lane_tx_striper
module tb_multi_lane_tx_striper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = 4'b0001;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        ready;
  logic [31:0] sym;
  logic [3:0]  k;
  logic [3:0]  vld;

  int n_assert = 0;
  int n_fail = 0;

  multi_lane_tx_striper #(.NUM_LANES(4), .DATA_WIDTH(8), .SKP_INTERVAL(2)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .lane_enable_i       (en),
    .data_frame_i        (data),
    .data_frame_valid_i  (valid),
    .data_frame_last_i   (last),
    .data_frame_ready_o  (ready),
    .lane_symbol_o       (sym),
    .lane_is_k_o         (k),
    .lane_symbol_valid_o (vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; last = 1'b0; data = 8'h00;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    data = d; last = l; valid = 1'b1;
    for (int i = 0; i < 16 && ready !== 1'b1; i++) step();
    chk("ready_wait", ready, 1);
    step();
    valid = 1'b0; last = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_sym", sym, 0);
    chk("rst_k", k, 0);
    chk("rst_vld", vld, 0);
    chk("rst_ready", ready, 0);
    rst = 1'b0;
    step();
    chk("ready_after_release", ready, 1);

    // x1: masks FF then 17 on lane 0 only
    send(8'h00, 1'b0);
    chk("x1_s0_sym", sym, 32'h0000_00FF);
    chk("x1_s0_vld", vld, 4'b0001);
    chk("x1_s0_k", k, 0);
    send(8'h00, 1'b1);
    chk("x1_s1_sym", sym, 32'h0000_0017);
    chk("x1_s1_vld", vld, 4'b0001);
    step();
    chk("x1_vld_pulse", vld, 0);

    // x4 full stripe
    do_reset();
    en = 4'b1111;
    send(8'h00, 1'b0);
    chk("x4_partial_vld", vld, 0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    chk("x4_sym", sym, 32'hFFFF_FFFF);
    chk("x4_vld", vld, 4'b1111);
    chk("x4_k", k, 0);

    // x4, 6 bytes: second stripe padded on lanes 2,3
    do_reset();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("pad_s0_sym", sym, 32'hFBFC_FDFE);
    chk("pad_s0_vld", vld, 4'b1111);
    send(8'h05, 1'b0); send(8'h06, 1'b1);
    chk("pad_s1_sym", sym, 32'hF7F7_1112);
    chk("pad_s1_k", k, 4'b1100);
    chk("pad_s1_vld", vld, 4'b1111);
    en = 4'b0011;
    send(8'h00, 1'b1);
    chk("idle_resample_sym", sym, 32'h0000_F7C0);
    chk("idle_resample_k", k, 4'b0010);
    chk("idle_resample_vld", vld, 4'b0011);

    // illegal mask behaves as x1
    do_reset();
    en = 4'b0101;
    send(8'h00, 1'b0);
    chk("ill_s0_sym", sym, 32'h0000_00FF);
    chk("ill_s0_vld", vld, 4'b0001);
    send(8'h00, 1'b1);
    chk("ill_s1_sym", sym, 32'h0000_0017);
    chk("ill_s1_vld", vld, 4'b0001);

    // width change mid-packet takes effect on next packet
    do_reset();
    en = 4'b1111;
    send(8'h00, 1'b0);
    en = 4'b0011;
    send(8'h00, 1'b0);
    chk("midchg_hold_vld", vld, 0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    chk("midchg_sym", sym, 32'hFFFF_FFFF);
    chk("midchg_vld", vld, 4'b1111);
    send(8'hAA, 1'b0);
    send(8'h55, 1'b1);
    chk("x2_sym", sym, 32'h0000_42BD);
    chk("x2_vld", vld, 4'b0011);
    chk("x2_k", k, 0);

    // x2 continuous bytes; SKP_INTERVAL = 2
    do_reset();
    en = 4'b0011;
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    chk("skp_s0_sym", sym, 32'h0000_FFFF);
    chk("skp_s0_vld", vld, 4'b0011);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    chk("skp_s1_sym", sym, 32'h0000_1717);
`ifdef MLC_SKP_INSERT_EN
    chk("skp_ready0", ready, 0);
    step();
    chk("com_sym", sym, 32'h0000_BCBC);
    chk("com_k", k, 4'b0011);
    chk("com_vld", vld, 4'b0011);
    chk("com_ready", ready, 0);
    step();
    chk("skp1_sym", sym, 32'h0000_1C1C);
    chk("skp1_ready", ready, 0);
    step();
    chk("skp2_sym", sym, 32'h0000_1C1C);
    chk("skp2_ready", ready, 0);
    step();
    chk("skp3_sym", sym, 32'h0000_1C1C);
    chk("skp3_k", k, 4'b0011);
    chk("skp3_ready", ready, 1);
    send(8'h00, 1'b0); send(8'h00, 1'b1);
    chk("post_skp_sym", sym, 32'h0000_FFFF);
    chk("post_skp_k", k, 0);
`else
    chk("no_skp_ready", ready, 1);
    send(8'h00, 1'b0); send(8'h00, 1'b1);
    chk("no_skp_s2_sym", sym, 32'h0000_C0C0);
    chk("no_skp_s2_vld", vld, 4'b0011);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
